// File: rtl/packet_demux.sv
// Purpose: 1-to-2 packet router; steers whole packets from port C to port A or B by one SOP data bit.
// Latency: 1 cycle from input acceptance to output valid (single registered holding stage).
// Backpressure: c_ready = !hold_full || ready of the tagged port; the non-selected port's ready is ignored.
// Optional: define PACKET_DEMUX_STATS_EN to build the packet/drop statistics counters (tied to 0 otherwise).

package packet_mux_pkg;
    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;
endpackage

module packet_demux #(
    parameter int DATA_W   = packet_mux_pkg::DATA_W,
    parameter int EMPTY_W  = packet_mux_pkg::EMPTY_W,
    parameter int DEST_BIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    // input stream
    input  logic [DATA_W-1:0]  c_data,
    input  logic               c_valid,
    input  logic               c_sop,
    input  logic               c_eop,
    input  logic [EMPTY_W-1:0] c_empty,
    input  logic               c_error,
    output logic               c_ready,
    // output port A
    output logic [DATA_W-1:0]  a_data,
    output logic               a_valid,
    output logic               a_sop,
    output logic               a_eop,
    output logic [EMPTY_W-1:0] a_empty,
    output logic               a_error,
    input  logic               a_ready,
    // output port B
    output logic [DATA_W-1:0]  b_data,
    output logic               b_valid,
    output logic               b_sop,
    output logic               b_eop,
    output logic [EMPTY_W-1:0] b_empty,
    output logic               b_error,
    input  logic               b_ready,
    // statistics
    output logic [CNT_W-1:0]   a_pkt_cnt,
    output logic [CNT_W-1:0]   b_pkt_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]  dat;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               err;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FWD_A = 2'd1,
        ST_FWD_B = 2'd2
    } state_t;

    state_t state_q, state_d;

    // holding register: one beat plus its destination tag (0 = A, 1 = B)
    beat_t  hold_q, hold_d;
    logic   hold_full_q, hold_full_d;
    logic   hold_dest_q, hold_dest_d;

    logic   tag_rdy;
    logic   out_xfer;
    logic   accept;
    logic   fwd;
    logic   fwd_dest;
    logic   err_frc;
    logic   sel_a;
    logic   sel_b;

    // Input readiness only looks at the port the held beat is waiting on.
    assign tag_rdy  = hold_dest_q ? b_ready : a_ready;
    assign out_xfer = hold_full_q && tag_rdy;
    assign c_ready  = !hold_full_q || tag_rdy;
    assign accept   = c_valid && c_ready;

    // Next-state and routing decision; the destination bit is only looked at on an SOP beat taken in IDLE.
    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        fwd_dest = hold_dest_q;
        err_frc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A non-SOP beat here is malformed: it is consumed but never forwarded.
                if (accept && c_sop) begin
                    fwd      = 1'b1;
                    fwd_dest = c_data[DEST_BIT];
                    if (!c_eop) begin
                        state_d = c_data[DEST_BIT] ? ST_FWD_B : ST_FWD_A;
                    end
                end
            end
            ST_FWD_A, ST_FWD_B: begin
                if (accept) begin
                    fwd      = 1'b1;
                    fwd_dest = (state_q == ST_FWD_B);
                    // An SOP inside a packet means the previous EOP went missing; keep the
                    // route so packets never split, but flag the beat as errored.
                    err_frc  = c_sop;
                    if (c_eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register update: drains on transfer, reloads on every forwarded beat.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_dest_d = hold_dest_q;
        if (out_xfer) begin
            hold_full_d = 1'b0;
        end
        if (fwd) begin
            hold_full_d  = 1'b1;
            hold_dest_d  = fwd_dest;
            hold_d.dat   = c_data;
            hold_d.sop   = c_sop;
            hold_d.eop   = c_eop;
            hold_d.empty = c_empty;
            hold_d.err   = c_error | err_frc;
        end
    end

    // State and holding register flops; reset discards any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_dest_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_dest_q <= hold_dest_d;
        end
    end

    // Only the tagged port sees the beat; the other port is held at all zeros.
    assign sel_a = hold_full_q && !hold_dest_q;
    assign sel_b = hold_full_q &&  hold_dest_q;

    assign a_valid = sel_a;
    assign a_data  = sel_a ? hold_q.dat   : '0;
    assign a_sop   = sel_a ? hold_q.sop   : 1'b0;
    assign a_eop   = sel_a ? hold_q.eop   : 1'b0;
    assign a_empty = sel_a ? hold_q.empty : '0;
    assign a_error = sel_a ? hold_q.err   : 1'b0;

    assign b_valid = sel_b;
    assign b_data  = sel_b ? hold_q.dat   : '0;
    assign b_sop   = sel_b ? hold_q.sop   : 1'b0;
    assign b_eop   = sel_b ? hold_q.eop   : 1'b0;
    assign b_empty = sel_b ? hold_q.empty : '0;
    assign b_error = sel_b ? hold_q.err   : 1'b0;

`ifdef PACKET_DEMUX_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             a_eop_xfer;
    logic             b_eop_xfer;
    logic             drop;
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign a_eop_xfer = out_xfer && !hold_dest_q && hold_q.eop;
    assign b_eop_xfer = out_xfer &&  hold_dest_q && hold_q.eop;
    assign drop       = accept && (state_q == ST_IDLE) && !c_sop;

    // Saturating counters; each event source increments its own counter independently.
    always_comb begin
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (a_eop_xfer && (a_cnt_q != '1)) begin
            a_cnt_d = a_cnt_q + CNT_ONE;
        end
        if (b_eop_xfer && (b_cnt_q != '1)) begin
            b_cnt_d = b_cnt_q + CNT_ONE;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    // Counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign a_pkt_cnt = a_cnt_q;
    assign b_pkt_cnt = b_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign a_pkt_cnt = '0;
    assign b_pkt_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_packet_demux.sv
// Purpose: self-checking bench for packet_demux, directed scenarios followed by random traffic.
// Latency: expects each accepted beat on its port one cycle later.
// Backpressure: random per-port readies; expected c_ready derived from what is pending per port.

module tb_packet_demux;

    localparam int DW       = packet_mux_pkg::DATA_W;
    localparam int EW       = packet_mux_pkg::EMPTY_W;
    localparam int DEST_BIT = 0;
    localparam int CNT_W    = 16;
`ifdef PACKET_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic          err;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DW-1:0]    c_data;
    logic             c_valid;
    logic             c_sop;
    logic             c_eop;
    logic [EW-1:0]    c_empty;
    logic             c_error;
    logic             c_ready;
    logic [DW-1:0]    a_data;
    logic             a_valid, a_sop, a_eop, a_error, a_ready;
    logic [EW-1:0]    a_empty;
    logic [DW-1:0]    b_data;
    logic             b_valid, b_sop, b_eop, b_error, b_ready;
    logic [EW-1:0]    b_empty;
    logic [CNT_W-1:0] a_pkt_cnt, b_pkt_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: what each port still owes, plus packet-level routing state
    beat_t qa[$];
    beat_t qb[$];
    bit    in_pkt = 1'b0;
    bit    route  = 1'b0;
    int    ca = 0, cb = 0, cd = 0;

    always #5 clk = ~clk;

    packet_demux #(
        .DATA_W(DW), .EMPTY_W(EW), .DEST_BIT(DEST_BIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .c_data(c_data), .c_valid(c_valid), .c_sop(c_sop), .c_eop(c_eop),
        .c_empty(c_empty), .c_error(c_error), .c_ready(c_ready),
        .a_data(a_data), .a_valid(a_valid), .a_sop(a_sop), .a_eop(a_eop),
        .a_empty(a_empty), .a_error(a_error), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_sop(b_sop), .b_eop(b_eop),
        .b_empty(b_empty), .b_error(b_error), .b_ready(b_ready),
        .a_pkt_cnt(a_pkt_cnt), .b_pkt_cnt(b_pkt_cnt), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < (1 << CNT_W) - 1) ? v + 1 : v;
    endfunction

    function automatic logic [63:0] ecnt(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    // Compare both output ports and counters with what the model says is owed.
    task automatic check_outputs();
        if (qa.size() != 0) begin
            chk("a_valid", 64'(a_valid), 64'd1);
            chk("a_data",  64'(a_data),  64'(qa[0].data));
            chk("a_sop",   64'(a_sop),   64'(qa[0].sop));
            chk("a_eop",   64'(a_eop),   64'(qa[0].eop));
            chk("a_empty", 64'(a_empty), 64'(qa[0].empty));
            chk("a_error", 64'(a_error), 64'(qa[0].err));
        end else begin
            chk("a_valid_idle", 64'(a_valid), 64'd0);
            if (qb.size() != 0) chk("a_data_idle", 64'(a_data), 64'd0);
        end
        if (qb.size() != 0) begin
            chk("b_valid", 64'(b_valid), 64'd1);
            chk("b_data",  64'(b_data),  64'(qb[0].data));
            chk("b_sop",   64'(b_sop),   64'(qb[0].sop));
            chk("b_eop",   64'(b_eop),   64'(qb[0].eop));
            chk("b_empty", 64'(b_empty), 64'(qb[0].empty));
            chk("b_error", 64'(b_error), 64'(qb[0].err));
        end else begin
            chk("b_valid_idle", 64'(b_valid), 64'd0);
            if (qa.size() != 0) chk("b_data_idle", 64'(b_data), 64'd0);
        end
        chk("a_pkt_cnt", 64'(a_pkt_cnt), ecnt(ca));
        chk("b_pkt_cnt", 64'(b_pkt_cnt), ecnt(cb));
        chk("drop_cnt",  64'(drop_cnt),  ecnt(cd));
    endtask

    // Packet-level routing rules applied to one accepted beat.
    task automatic model_accept(input beat_t bt);
        beat_t o;
        o = bt;
        if (!in_pkt) begin
            if (bt.sop) begin
                route  = bt.data[DEST_BIT];
                in_pkt = !bt.eop;
                if (route) qb.push_back(o); else qa.push_back(o);
            end else begin
                cd = sat(cd);
            end
        end else begin
            o.err = bt.err | bt.sop;
            if (route) qb.push_back(o); else qa.push_back(o);
            if (bt.eop) in_pkt = 1'b0;
        end
    endtask

    // One clock cycle: check outputs, drive inputs, check c_ready, advance the model.
    task automatic cyc(input logic v, input beat_t bt, input logic ar, input logic br,
                       output logic acc);
        logic exp_rdy;
        @(negedge clk);
        check_outputs();
        c_valid = v;
        c_data  = bt.data;
        c_sop   = bt.sop;
        c_eop   = bt.eop;
        c_empty = bt.empty;
        c_error = bt.err;
        a_ready = ar;
        b_ready = br;
        #1;
        exp_rdy = (qa.size() == 0 && qb.size() == 0) || (qa.size() != 0 && ar) ||
                  (qb.size() != 0 && br);
        chk("c_ready", 64'(c_ready), 64'(exp_rdy));
        acc = v && c_ready;
        if (qa.size() != 0 && ar) begin
            if (qa[0].eop) ca = sat(ca);
            void'(qa.pop_front());
        end
        if (qb.size() != 0 && br) begin
            if (qb[0].eop) cb = sat(cb);
            void'(qb.pop_front());
        end
        if (v && exp_rdy) model_accept(bt);
        @(posedge clk);
    endtask

    // Present one beat that must be accepted in this cycle.
    task automatic send(input string tag, input logic [DW-1:0] d, input logic s, input logic e,
                        input logic er, input logic ar, input logic br);
        beat_t b;
        logic  acc;
        b = '{data: d, sop: s, eop: e, empty: EW'(d), err: er};
        cyc(1'b1, b, ar, br, acc);
        chk(tag, 64'(acc), 64'd1);
    endtask

    initial begin
        beat_t cur;
        beat_t idle_b;
        logic  acc;
        bit    have;

        idle_b  = '0;
        rst_n   = 1'b0;
        c_valid = 1'b0;
        c_data  = '0;
        c_sop   = 1'b0;
        c_eop   = 1'b0;
        c_empty = '0;
        c_error = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_c_ready", 64'(c_ready), 64'd1);
        rst_n = 1'b1;

        // 4-beat packet to A, all readies high
        send("a4_acc0", 32'h1000_0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send("a4_acc1", 32'h1000_0021, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send("a4_acc2", 32'h1000_0033, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send("a4_acc3", 32'h1000_0045, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);

        // single-beat packet to B then back-to-back packet to A, no bubble
        send("sb_b",    32'h2000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send("nb_a0",   32'h2000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send("nb_a1",   32'h2000_0004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);

        // packet to B with b_ready low 3 cycles mid-packet; a_ready low throughout
        send("st_b0",   32'h3000_0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send("st_b1",   32'h3000_0022, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cur = '{data: 32'h3000_0034, sop: 1'b0, eop: 1'b0, empty: 2'd1, err: 1'b0};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, cur, 1'b0, 1'b0, acc);
            chk("st_block", 64'(acc), 64'd0);
        end
        send("st_b2",   32'h3000_0034, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send("st_b3",   32'h3000_0046, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);

        // malformed beats in IDLE are consumed and dropped
        send("drop0",   32'h4000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send("drop1",   32'h4000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);

        // SOP inside a packet to A: stays on A with error forced
        send("ms_a0",   32'h5000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send("ms_sop",  32'h5000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send("ms_mid",  32'h5000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send("ms_eop",  32'h5000_0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);

        // reset mid-packet with the holding register full
        send("rs_a0",   32'h6000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outputs();
        #2;
        rst_n   = 1'b0;
        c_valid = 1'b0;
        #1;
        chk("rst_async_a_valid", 64'(a_valid), 64'd0);
        chk("rst_async_b_valid", 64'(b_valid), 64'd0);
        chk("rst_async_a_cnt",   64'(a_pkt_cnt), 64'd0);
        chk("rst_async_b_cnt",   64'(b_pkt_cnt), 64'd0);
        chk("rst_async_d_cnt",   64'(drop_cnt), 64'd0);
        qa.delete();
        qb.delete();
        in_pkt = 1'b0;
        ca = 0;
        cb = 0;
        cd = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // post-reset packet to B
        send("pr_b0",   32'h7000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send("pr_b1",   32'h7000_0002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);

        // random traffic with random backpressure; beats held stable until accepted
        have = 1'b0;
        cur  = '0;
        for (int i = 0; i < 800; i++) begin
            if (!have && $urandom_range(3) != 0) begin
                have      = 1'b1;
                cur.data  = DW'($urandom);
                cur.sop   = in_pkt ? ($urandom_range(9) == 0) : ($urandom_range(7) != 0);
                cur.eop   = ($urandom_range(2) == 0);
                cur.empty = EW'($urandom);
                cur.err   = ($urandom_range(7) == 0);
            end
            cyc(have, cur, ($urandom_range(3) != 0), ($urandom_range(3) != 0), acc);
            if (acc) have = 1'b0;
        end

        // drain and final check
        repeat (4) cyc(1'b0, idle_b, 1'b1, 1'b1, acc);
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
